// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: ID-stage control decode, load-use detection and ID/EX control register.
// Optional illegal-opcode trap (exIllegal_o, illegalCount_o) is built when ILLEGAL_TRAP_EN is defined.
module id_ex_ctrl_pipe #(
  parameter int INSTR_W = 16
`ifdef ILLEGAL_TRAP_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               idValid_i,
  input  logic               stallIn_i,
  input  logic               flush_i,
  output logic               stallReq_o,
`ifdef ILLEGAL_TRAP_EN
  output logic               exIllegal_o,
  output logic [CNT_W-1:0]   illegalCount_o,
`endif
  output logic               exValid_o,
  output logic [2:0]         exAluOp_o,
  output logic [3:0]         exFunCode_o,
  output logic               exAluSrc_o,
  output logic               exRegWrite_o,
  output logic               exMemRead_o,
  output logic               exMemWrite_o,
  output logic               exMemToReg_o,
  output logic               exBranch_o,
  output logic [3:0]         exDestReg_o
);
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_ANDI = 4'b0111;
  localparam logic [3:0] OP_ORI  = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic [3:0] fun;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [3:0] dest;
  } ctrl_t;
  ctrl_t dec, ex_q, ex_d;
  logic [3:0] op, rs, rt;
  logic rd_rt, load_use, kill;
  assign op = instr_i[15:12];
  assign rs = instr_i[11:8];
  assign rt = instr_i[7:4];
  always_comb begin
    dec = '0;
    rd_rt = 1'b0;
    case (op)
      OP_R:    begin dec.reg_write = 1'b1; dec.dest = rs; rd_rt = 1'b1; end
      OP_LW:   begin dec.alu_op = 3'b010; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; dec.dest = rt; end
      OP_SW:   begin dec.alu_op = 3'b010; dec.alu_src = 1'b1; dec.mem_write = 1'b1; rd_rt = 1'b1; end
      OP_BEQ:  begin dec.alu_op = 3'b011; dec.branch = 1'b1; rd_rt = 1'b1; end
      OP_ANDI: begin dec.alu_op = 3'b100; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.dest = rt; end
      OP_ORI:  begin dec.alu_op = 3'b110; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.dest = rt; end
      default: ;
    endcase
    dec.valid = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ANDI, OP_ORI};
    dec.fun = dec.valid ? instr_i[3:0] : 4'h0;
  end
  // every legal op reads rs, so dec.valid doubles as the rs-read flag
  assign load_use = ex_q.valid & ex_q.mem_read & idValid_i &
                    ((dec.valid & (ex_q.dest == rs)) | (rd_rt & (ex_q.dest == rt)));
  assign stallReq_o = load_use & ~flush_i & ~stallIn_i & ~rst;
  assign kill = load_use | ~idValid_i;
  assign ex_d = flush_i ? ctrl_t'('0) : stallIn_i ? ex_q : kill ? ctrl_t'('0) : dec;
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else ex_q <= ex_d;
  end
  assign exValid_o    = ex_q.valid;
  assign exAluOp_o    = ex_q.alu_op;
  assign exFunCode_o  = ex_q.fun;
  assign exAluSrc_o   = ex_q.alu_src;
  assign exRegWrite_o = ex_q.reg_write;
  assign exMemRead_o  = ex_q.mem_read;
  assign exMemWrite_o = ex_q.mem_write;
  assign exMemToReg_o = ex_q.mem_to_reg;
  assign exBranch_o   = ex_q.branch;
  assign exDestReg_o  = ex_q.dest;
`ifdef ILLEGAL_TRAP_EN
  logic ill_q, ill_d, dec_ill, cnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign dec_ill = ~dec.valid & (op != OP_NOP);
  assign ill_d = flush_i ? 1'b0 : stallIn_i ? ill_q : kill ? 1'b0 : dec_ill;
  assign cnt_inc = ~flush_i & ~stallIn_i & ~kill & dec_ill & ~&cnt_q;
  assign cnt_d = cnt_inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end
  assign exIllegal_o = ill_q;
  assign illegalCount_o = cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb_id_ex_ctrl_pipe: table-driven scoreboard bench for id_ex_ctrl_pipe (default build; trap ports checked when ILLEGAL_TRAP_EN is defined).
module tb_id_ex_ctrl_pipe;
  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        idv;
    logic        si;
    logic        fl;
    logic        stall;
    logic [17:0] ex;
    logic        ill;
  } vec_t;
  typedef struct {
    logic [17:0] ex;
    logic        ill;
  } exp_t;
  localparam logic [5:0] CR = 6'b010000, CLW = 6'b111010, CSW = 6'b100100;
  localparam logic [5:0] CBQ = 6'b000001, CI = 6'b110000;
  localparam logic [17:0] BUB = 18'h0;
  logic clk = 1'b0, rst = 1'b1, idValid = 1'b0, stallIn = 1'b0, flush = 1'b0;
  logic [15:0] instr = 16'h0;
  logic stallReq, exValid, exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch;
  logic [2:0] exAluOp;
  logic [3:0] exFunCode, exDestReg;
  logic [17:0] act;
  int n_vec = 0, miss = 0;
  vec_t tbl[$];
  exp_t sb[$];
`ifdef ILLEGAL_TRAP_EN
  logic exIllegal;
  logic [7:0] illegalCount;
  int cnt_exp = 0;
`endif
  id_ex_ctrl_pipe dut (
    .clk(clk), .rst(rst), .instr_i(instr), .idValid_i(idValid), .stallIn_i(stallIn), .flush_i(flush),
    .stallReq_o(stallReq),
`ifdef ILLEGAL_TRAP_EN
    .exIllegal_o(exIllegal), .illegalCount_o(illegalCount),
`endif
    .exValid_o(exValid), .exAluOp_o(exAluOp), .exFunCode_o(exFunCode), .exAluSrc_o(exAluSrc),
    .exRegWrite_o(exRegWrite), .exMemRead_o(exMemRead), .exMemWrite_o(exMemWrite),
    .exMemToReg_o(exMemToReg), .exBranch_o(exBranch), .exDestReg_o(exDestReg)
  );
  always #5 clk = ~clk;
  assign act = {exValid, exAluOp, exFunCode, exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch, exDestReg};
  function automatic logic [17:0] mk(input logic [2:0] a, input logic [3:0] f, input logic [5:0] c, input logic [3:0] d);
    return {1'b1, a, f, c, d};
  endfunction
  function automatic vec_t V(input logic r, input logic [15:0] i, input logic idv, input logic si, input logic fl,
                             input logic st, input logic [17:0] ex, input logic ill);
    vec_t v;
    v.rst = r; v.instr = i; v.idv = idv; v.si = si; v.fl = fl; v.stall = st; v.ex = ex; v.ill = ill;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    exp_t e;
    rst = v.rst; instr = v.instr; idValid = v.idv; stallIn = v.si; flush = v.fl;
    #1;
    n_vec++;
    if (stallReq !== v.stall) begin
      miss++;
      $display("FAIL stallReq vec %0d instr=%h: got %b want %b", n_vec, v.instr, stallReq, v.stall);
    end
    sb.push_back('{v.ex, v.ill});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (act !== e.ex) begin
      miss++;
      $display("FAIL ex_outputs vec %0d instr=%h: got %h want %h", n_vec, v.instr, act, e.ex);
    end
`ifdef ILLEGAL_TRAP_EN
    if (v.rst) cnt_exp = 0;
    else if (e.ill && cnt_exp != 255) cnt_exp++;
    if (exIllegal !== e.ill) begin
      miss++;
      $display("FAIL exIllegal vec %0d: got %b want %b", n_vec, exIllegal, e.ill);
    end
    if (illegalCount !== cnt_exp[7:0]) begin
      miss++;
      $display("FAIL illegalCount vec %0d: got %0d want %0d", n_vec, illegalCount, cnt_exp);
    end
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tbl.push_back(V(1, 16'h0123, 1, 0, 0, 0, BUB, 0));
    tbl.push_back(V(1, 16'h0123, 1, 0, 0, 0, BUB, 0));
    tbl.push_back(V(0, 16'h0125, 1, 0, 0, 0, mk(3'b000, 4'h5, CR, 4'h1), 0));
    tbl.push_back(V(0, 16'h4234, 1, 0, 0, 0, mk(3'b010, 4'h4, CLW, 4'h3), 0));
    tbl.push_back(V(0, 16'h5567, 1, 0, 0, 0, mk(3'b010, 4'h7, CSW, 4'h0), 0));
    tbl.push_back(V(0, 16'h6128, 1, 0, 0, 0, mk(3'b011, 4'h8, CBQ, 4'h0), 0));
    tbl.push_back(V(0, 16'h7459, 1, 0, 0, 0, mk(3'b100, 4'h9, CI, 4'h5), 0));
    tbl.push_back(V(0, 16'h867A, 1, 0, 0, 0, mk(3'b110, 4'hA, CI, 4'h7), 0));
    tbl.push_back(V(0, 16'h4130, 1, 0, 0, 0, mk(3'b010, 4'h0, CLW, 4'h3), 0));
    tbl.push_back(V(0, 16'h0341, 1, 0, 0, 1, BUB, 0));
    tbl.push_back(V(0, 16'h0341, 1, 0, 0, 0, mk(3'b000, 4'h1, CR, 4'h3), 0));
    tbl.push_back(V(0, 16'h4213, 1, 0, 0, 0, mk(3'b010, 4'h3, CLW, 4'h1), 0));
    tbl.push_back(V(0, 16'h5A1F, 1, 0, 0, 1, BUB, 0));
    tbl.push_back(V(0, 16'h5A1F, 1, 0, 0, 0, mk(3'b010, 4'hF, CSW, 4'h0), 0));
    tbl.push_back(V(0, 16'h4025, 1, 0, 0, 0, mk(3'b010, 4'h5, CLW, 4'h2), 0));
    tbl.push_back(V(0, 16'h7329, 1, 0, 0, 0, mk(3'b100, 4'h9, CI, 4'h2), 0));
    tbl.push_back(V(0, 16'h4044, 1, 0, 0, 0, mk(3'b010, 4'h4, CLW, 4'h4), 0));
    tbl.push_back(V(0, 16'h0400, 0, 0, 0, 0, BUB, 0));
    tbl.push_back(V(0, 16'h8ABC, 1, 0, 0, 0, mk(3'b110, 4'hC, CI, 4'hB), 0));
    tbl.push_back(V(0, 16'h0123, 1, 1, 0, 0, mk(3'b110, 4'hC, CI, 4'hB), 0));
    tbl.push_back(V(0, 16'h0123, 1, 1, 0, 0, mk(3'b110, 4'hC, CI, 4'hB), 0));
    tbl.push_back(V(0, 16'h0123, 1, 1, 0, 0, mk(3'b110, 4'hC, CI, 4'hB), 0));
    tbl.push_back(V(0, 16'h0123, 1, 0, 0, 0, mk(3'b000, 4'h3, CR, 4'h1), 0));
    tbl.push_back(V(0, 16'h4012, 1, 0, 0, 0, mk(3'b010, 4'h2, CLW, 4'h1), 0));
    tbl.push_back(V(0, 16'h0100, 1, 1, 1, 0, BUB, 0));
    tbl.push_back(V(0, 16'h4012, 1, 0, 0, 0, mk(3'b010, 4'h2, CLW, 4'h1), 0));
    tbl.push_back(V(0, 16'h0100, 1, 1, 0, 0, mk(3'b010, 4'h2, CLW, 4'h1), 0));
    tbl.push_back(V(0, 16'h0100, 1, 0, 0, 1, BUB, 0));
    tbl.push_back(V(0, 16'h0100, 1, 0, 0, 0, mk(3'b000, 4'h0, CR, 4'h1), 0));
    tbl.push_back(V(0, 16'hF123, 1, 0, 0, 0, BUB, 0));
    tbl.push_back(V(0, 16'hA123, 1, 0, 0, 0, BUB, 1));
    tbl.push_back(V(0, 16'hA123, 1, 0, 0, 0, BUB, 1));
    tbl.push_back(V(0, 16'hA123, 1, 0, 0, 0, BUB, 1));
    tbl.push_back(V(0, 16'h4012, 1, 0, 0, 0, mk(3'b010, 4'h2, CLW, 4'h1), 0));
    tbl.push_back(V(1, 16'h0100, 1, 0, 0, 0, BUB, 0));
    tbl.push_back(V(0, 16'h0100, 1, 0, 0, 0, mk(3'b000, 4'h0, CR, 4'h1), 0));
    tbl.push_back(V(0, 16'h867A, 1, 0, 1, 0, BUB, 0));
    @(posedge clk);
    #1;
    foreach (tbl[k]) apply(tbl[k]);
    // back-to-back loads: each dependent consumer costs exactly one bubble
    apply(V(0, 16'h4152, 1, 0, 0, 0, mk(3'b010, 4'h2, CLW, 4'h5), 0));
    apply(V(0, 16'h4563, 1, 0, 0, 1, BUB, 0));
    apply(V(0, 16'h4563, 1, 0, 0, 0, mk(3'b010, 4'h3, CLW, 4'h6), 0));
    apply(V(0, 16'h6061, 1, 0, 0, 1, BUB, 0));
    apply(V(0, 16'h6061, 1, 0, 0, 0, mk(3'b011, 4'h1, CBQ, 4'h0), 0));
    apply(V(0, 16'h0000, 0, 0, 0, 0, BUB, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end
endmodule
